bp_resolve_ctrl: RTL and testbench

//  Resolution/update controller for the IF-stage branch predictor. Carries each IF prediction to ID,

---
 rtl/bp_resolve_ctrl_pkg.sv | 23 ++
 rtl/bp_resolve_ctrl_sat_cnt.sv | 27 ++
 rtl/bp_resolve_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bp_resolve_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_resolve_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bp_resolve_ctrl_pkg
//   Shared definitions for the branch-resolution controller.
//   - PC_W / INST_STEP : fetch address width and sequential instruction step
//   - state_t          : resolution FSM state codes (IDLE=0, SQUASH=1)
//   - seq_pc()         : fall-through PC of an instruction (wraps mod 2^PC_W)
// ---------------------------------------------------------------------------
package bp_resolve_ctrl_pkg;

    localparam int              PC_W      = 32;
    localparam logic [PC_W-1:0] INST_STEP = 32'd4;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_t;

    // Natural modulo-2^PC_W arithmetic gives the required wrap at 0xFFFFFFFC.
    function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
        return pc + INST_STEP;
    endfunction

endpackage

// File: rtl/bp_resolve_ctrl_sat_cnt.sv
// ---------------------------------------------------------------------------
// bp_sat_cnt
//   CNT_W-bit event counter that increments on inc and sticks at all-ones.
//   Ports:
//     clk   in   clock
//     rst_n in   asynchronous active-low reset (clears the count)
//     inc   in   count one event this cycle
//     cnt   out  current count
// ---------------------------------------------------------------------------
module bp_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bp_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// bp_resolve_ctrl
//   Resolution/update controller for the IF-stage branch predictor.
//   The IF-stage prediction is carried alongside the instruction into ID,
//   compared with the resolved outcome, and turned into registered one-cycle
//   predictor/BTB update strobes. A mispredict redirects fetch and kills the
//   next SQUASH_CYC wrong-path cycles. Saturating counters track resolved
//   branches/jumps and mispredicts.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     stall_id            IF/ID held: no capture, no resolution
//     pc_if, sel_bj_pc_if, pre_taken_if, pre_bjpc_if   IF-stage prediction
//     id_valid, id_is_branch, id_is_jump, id_taken, id_target  ID resolution
//     ud_pdt, ud_BTB      direction-table / BTB update strobes
//     real_br_taken, real_bjpc, pc_upd   update payload
//     redirect, redirect_pc               fetch correction
//     flush               kill IF/ID contents (wrong path)
//     br_cnt, mis_cnt     saturating performance counters
// ---------------------------------------------------------------------------
module bp_resolve_ctrl
    import bp_resolve_ctrl_pkg::*;
#(
    parameter int SQUASH_CYC = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_id,
    input  logic [31:0]      pc_if,
    input  logic             sel_bj_pc_if,
    input  logic             pre_taken_if,
    input  logic [31:0]      pre_bjpc_if,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_is_jump,
    input  logic             id_taken,
    input  logic [31:0]      id_target,
    output logic             ud_pdt,
    output logic             ud_BTB,
    output logic             real_br_taken,
    output logic [31:0]      real_bjpc,
    output logic [31:0]      pc_upd,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYC - 1);

    state_t          state_reg, state_next;
    logic [2:0]      sq_cnt_reg, sq_cnt_next;

    logic            pr_sel_reg;
    logic [PC_W-1:0] pr_tgt_reg;
    logic [PC_W-1:0] pr_pc_reg;

    logic            res;
    logic            act;
    logic            tgt_diff;
    logic            mis;
    logic            btb_wr;
    logic [PC_W-1:0] correct_pc;

    // A predicted redirect already implies a taken prediction, so the
    // separate direction bit carries no extra information for resolution.
    logic            unused_pre_taken;
    assign unused_pre_taken = pre_taken_if;

    // Wrong-path cycles are killed purely from the FSM state.
    assign flush = (state_reg == SQUASH);

    // ---------------- prediction register (travels IF -> ID) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_sel_reg <= 1'b0;
            pr_tgt_reg <= '0;
            pr_pc_reg  <= '0;
        end else if (flush) begin
            // Whatever sits in IF during a squash is wrong path: insert a bubble.
            pr_sel_reg <= 1'b0;
            pr_tgt_reg <= '0;
            pr_pc_reg  <= '0;
        end else if (!stall_id) begin
            pr_sel_reg <= sel_bj_pc_if;
            pr_tgt_reg <= pre_bjpc_if;
            pr_pc_reg  <= pc_if;
        end
    end

    // ---------------- resolution / mispredict compare ----------------
    always_comb begin
        res        = id_valid && !stall_id && (state_reg == IDLE) &&
                     (id_is_branch || id_is_jump);
        act        = id_is_jump || (id_is_branch && id_taken);
        tgt_diff   = (id_target != pr_tgt_reg);
        correct_pc = act ? id_target : seq_pc(pr_pc_reg);
        // Taken-and-predicted-taken still mispredicts if the target differs.
        mis        = res && ((act != pr_sel_reg) || (act && pr_sel_reg && tgt_diff));
        btb_wr     = res && act && (!pr_sel_reg || tgt_diff);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sq_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            sq_cnt_reg <= sq_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sq_cnt_next = sq_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (mis) begin
                    state_next  = SQUASH;
                    sq_cnt_next = SQ_LOAD;
                end
            end
            SQUASH: begin
                if (sq_cnt_reg == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    sq_cnt_next = sq_cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next  = IDLE;
                sq_cnt_next = '0;
            end
        endcase
    end

    // ---------------- registered update / redirect outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ud_pdt        <= 1'b0;
            ud_BTB        <= 1'b0;
            real_br_taken <= 1'b0;
            real_bjpc     <= '0;
            pc_upd        <= '0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
        end else begin
            ud_pdt        <= res && id_is_branch;
            ud_BTB        <= btb_wr;
            real_br_taken <= act;
            real_bjpc     <= id_target;
            pc_upd        <= pr_pc_reg;
            redirect      <= mis;
            if (mis) begin
                redirect_pc <= correct_pc;
            end
        end
    end

    // ---------------- performance counters ----------------
    bp_sat_cnt #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res),
        .cnt   (br_cnt)
    );

    bp_sat_cnt #(.CNT_W(CNT_W)) u_mis_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mis),
        .cnt   (mis_cnt)
    );

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Bench for bp_resolve_ctrl: directed vectors push expected update/redirect
// records into a scoreboard; a monitor pops one record per presented strobe.
module tb_bp_resolve_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             stall_id;
    logic [31:0]      pc_if;
    logic             sel_bj_pc_if;
    logic             pre_taken_if;
    logic [31:0]      pre_bjpc_if;
    logic             id_valid;
    logic             id_is_branch;
    logic             id_is_jump;
    logic             id_taken;
    logic [31:0]      id_target;
    logic             ud_pdt;
    logic             ud_BTB;
    logic             real_br_taken;
    logic [31:0]      real_bjpc;
    logic [31:0]      pc_upd;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    bp_resolve_ctrl #(.SQUASH_CYC(2), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_id      (stall_id),
        .pc_if         (pc_if),
        .sel_bj_pc_if  (sel_bj_pc_if),
        .pre_taken_if  (pre_taken_if),
        .pre_bjpc_if   (pre_bjpc_if),
        .id_valid      (id_valid),
        .id_is_branch  (id_is_branch),
        .id_is_jump    (id_is_jump),
        .id_taken      (id_taken),
        .id_target     (id_target),
        .ud_pdt        (ud_pdt),
        .ud_BTB        (ud_BTB),
        .real_br_taken (real_br_taken),
        .real_bjpc     (real_bjpc),
        .pc_upd        (pc_upd),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .br_cnt        (br_cnt),
        .mis_cnt       (mis_cnt)
    );

    typedef struct packed {
        logic        pdt;
        logic        btb;
        logic        tk;
        logic [31:0] bjpc;
        logic [31:0] pcu;
        logic        rd;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic pdt, input logic btb, input logic tk,
                                input logic [31:0] bjpc, input logic [31:0] pcu,
                                input logic rd, input logic [31:0] rpc);
        exp_t e;
        e.pdt = pdt; e.btb = btb; e.tk = tk; e.bjpc = bjpc;
        e.pcu = pcu; e.rd = rd; e.rpc = rpc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    // Monitor: every presented strobe consumes one expected record.
    always @(negedge clk) begin
        if (rst_n && (ud_pdt || ud_BTB || redirect)) begin
            exp_t got;
            got = mk(ud_pdt, ud_BTB, real_br_taken, real_bjpc, pc_upd, redirect, redirect_pc);
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got pdt=%0b btb=%0b rd=%0b pc_upd=0x%08h, expected no strobe",
                         ud_pdt, ud_BTB, redirect, pc_upd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL update: got pdt=%0b btb=%0b tk=%0b bjpc=0x%08h pcu=0x%08h rd=%0b rpc=0x%08h expected pdt=%0b btb=%0b tk=%0b bjpc=0x%08h pcu=0x%08h rd=%0b rpc=0x%08h",
                             got.pdt, got.btb, got.tk, got.bjpc, got.pcu, got.rd, got.rpc,
                             e.pdt, e.btb, e.tk, e.bjpc, e.pcu, e.rd, e.rpc);
                end else begin
                    $display("ok   update pc_upd=0x%08h pdt=%0b btb=%0b rd=%0b rpc=0x%08h",
                             got.pcu, got.pdt, got.btb, got.rd, got.rpc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_if;
        pc_if = 32'h0; sel_bj_pc_if = 1'b0; pre_taken_if = 1'b0; pre_bjpc_if = 32'h0;
    endtask

    task automatic clear_id;
        id_valid = 1'b0; id_is_branch = 1'b0; id_is_jump = 1'b0;
        id_taken = 1'b0; id_target = 32'h0;
    endtask

    // Cycle A: prediction in IF. Cycle B: same instruction resolved in ID.
    // Returns one cycle after the resolving edge (outputs/counters visible).
    task automatic issue(input logic [31:0] pc, input logic sel, input logic [31:0] ptgt,
                         input logic is_br, input logic is_j, input logic tk,
                         input logic [31:0] tgt, input logic exp_out, input exp_t e);
        pc_if = pc; sel_bj_pc_if = sel; pre_taken_if = sel; pre_bjpc_if = ptgt;
        clear_id();
        tick();
        clear_if();
        id_valid = 1'b1; id_is_branch = is_br; id_is_jump = is_j;
        id_taken = tk; id_target = tgt;
        if (exp_out) sb.push_back(e);
        tick();
        clear_id();
    endtask

    initial begin
        rst_n = 1'b0;
        stall_id = 1'b0;
        clear_if();
        clear_id();
        #2;
        chk("reset_outputs", {29'h0, ud_pdt, ud_BTB, redirect}, 32'h0);
        chk("reset_flush", {31'h0, flush}, 32'h0);
        chk("reset_br_cnt", 32'(br_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Correctly predicted taken beq
        issue(32'h10, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1,
              mk(1'b1, 1'b0, 1'b1, 32'h40, 32'h10, 1'b0, 32'h0));
        chk("t2_br_cnt", 32'(br_cnt), 32'd1);
        chk("t2_flush", {31'h0, flush}, 32'h0);

        // Correctly predicted not-taken branch
        issue(32'h14, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1,
              mk(1'b1, 1'b0, 1'b0, 32'h80, 32'h14, 1'b0, 32'h0));
        chk("nt_br_cnt", 32'(br_cnt), 32'd2);

        // Non-branch valid instruction: no strobe, no count
        issue(32'h18, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
              mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0));
        chk("nb_br_cnt", 32'(br_cnt), 32'd2);

        // Unpredicted jump 0x100 -> 0x200
        issue(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1,
              mk(1'b0, 1'b1, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200));
        chk("t3_mis_cnt", 32'(mis_cnt), 32'd1);
        chk("t3_br_cnt", 32'(br_cnt), 32'd3);
        chk("t3_flush_c1", {31'h0, flush}, 32'h1);
        tick();
        chk("t3_flush_c2", {31'h0, flush}, 32'h1);
        tick();
        chk("t3_flush_end", {31'h0, flush}, 32'h0);

        // Predicted taken, resolved not-taken at the top of the address space
        issue(32'hFFFF_FFFC, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1,
              mk(1'b1, 1'b0, 1'b0, 32'h80, 32'hFFFF_FFFC, 1'b1, 32'h0));
        chk("t4_mis_cnt", 32'(mis_cnt), 32'd2);

        // Mispredicting branch in ID during both SQUASH cycles: discarded
        id_valid = 1'b1; id_is_branch = 1'b1; id_taken = 1'b1; id_target = 32'h300;
        tick();
        tick();
        clear_id();
        tick();
        chk("t5_sq_br_cnt", 32'(br_cnt), 32'd4);
        chk("t5_sq_mis_cnt", 32'(mis_cnt), 32'd2);

        // Stalled mispredicting branch: retained, resolved once after release
        pc_if = 32'h500;
        tick();
        pc_if = 32'h999; sel_bj_pc_if = 1'b1; pre_taken_if = 1'b1; pre_bjpc_if = 32'h77;
        id_valid = 1'b1; id_is_branch = 1'b1; id_taken = 1'b1; id_target = 32'h600;
        stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_stall_br_cnt", 32'(br_cnt), 32'd4);
        end
        stall_id = 1'b0;
        clear_if();
        sb.push_back(mk(1'b1, 1'b1, 1'b1, 32'h600, 32'h500, 1'b1, 32'h600));
        tick();
        clear_id();
        chk("t5_rel_br_cnt", 32'(br_cnt), 32'd5);
        chk("t5_rel_mis_cnt", 32'(mis_cnt), 32'd3);
        tick();
        tick();

        // Predicted jump with wrong target, then reset in the middle of SQUASH
        issue(32'h20, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1,
              mk(1'b0, 1'b1, 1'b1, 32'h44, 32'h20, 1'b1, 32'h44));
        chk("wt_mis_cnt", 32'(mis_cnt), 32'd4);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_outputs", {29'h0, ud_pdt, ud_BTB, redirect}, 32'h0);
        chk("t1_flush", {31'h0, flush}, 32'h0);
        chk("t1_redirect_pc", redirect_pc, 32'h0);
        chk("t1_br_cnt", 32'(br_cnt), 32'h0);
        chk("t1_mis_cnt", 32'(mis_cnt), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Saturation: 17 correctly predicted branches on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            issue(32'h1000 + 32'(i * 4), 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1,
                  mk(1'b1, 1'b0, 1'b1, 32'h40, 32'h1000 + 32'(i * 4), 1'b0, 32'h0));
            if (i == 14) chk("t6_br_cnt_full", 32'(br_cnt), 32'hF);
        end
        chk("t6_br_cnt_sat", 32'(br_cnt), 32'hF);
        chk("t6_mis_cnt", 32'(mis_cnt), 32'h0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
